// File: rtl/serial_arith_pkg.sv
// ============================================================================
// serial_arith_pkg : state encoding and sizing helpers for bit-serial blocks
// Revision 1.0
// ============================================================================
`default_nettype none

package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of a counter that must reach w-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/half_subtractor.sv
// ============================================================================
// half_subtractor : one-bit x - y, difference and borrow-out
// Revision 1.0
// ============================================================================
`default_nettype none

module half_subtractor (
  input  logic x,
  input  logic y,
  output logic diff,
  output logic bout
);

  assign diff = x ^ y;
  assign bout = ~x & y;

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// serial_subtractor : bit-serial unsigned a - b, LSB first, start/done handshake
// Revision 1.0
// ============================================================================
`default_nettype none

module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         borrow
);

  localparam int CW = cnt_width(W);

  state_e          state_q, state_d;
  logic [W-1:0]    sa_q, sa_d, sb_q, sb_d;
  logic [W-2:0]    sr_q, sr_d;
  logic [W-1:0]    diff_q, diff_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            bf_q, bf_d;
  logic            borrow_q, borrow_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            d1, bo1, d_bit, bo2, bf_next, last_bit;
  logic [W-2:0]    sr_shift;

  // Full-subtractor cell: two half subtractors, borrows merged by OR.
  half_subtractor u_hs_ab (
    .x    (sa_q[0]),
    .y    (sb_q[0]),
    .diff (d1),
    .bout (bo1)
  );

  half_subtractor u_hs_bf (
    .x    (d1),
    .y    (bf_q),
    .diff (d_bit),
    .bout (bo2)
  );

  assign bf_next  = bo1 | bo2;
  assign last_bit = (cnt_q == CW'(W - 1));

  // sr only needs the first W-1 result bits; the last one joins directly.
  generate
    if (W == 2) begin : g_sr_narrow
      assign sr_shift = d_bit;
    end else begin : g_sr_wide
      assign sr_shift = {d_bit, sr_q[W-2:1]};
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sr_d     = sr_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    bf_d     = bf_q;
    borrow_d = borrow_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          bf_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sa_d = sa_q >> 1;
        sb_d = sb_q >> 1;
        sr_d = sr_shift;
        bf_d = bf_next;
        if (last_bit) begin
          diff_d   = {d_bit, sr_q};
          borrow_d = bf_next;
          cnt_d    = '0;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sr_q     <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bf_q     <= 1'b0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sr_q     <= sr_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      bf_q     <= bf_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

`default_nettype wire
